// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI front end: allocator FSM states, default
// note/velocity widths and the MIDI status bytes also used by the parser.
package midi_pkg;

  localparam int NOTE_W_DEF = 7;
  localparam int VEL_W_DEF  = 7;

  // MIDI status bytes (channel nibble zero)
  localparam logic [7:0] MIDI_NOTE_OFF  = 8'h80;
  localparam logic [7:0] MIDI_NOTE_ON   = 8'h90;
  localparam logic [7:0] MIDI_PROG_CHG  = 8'hC0;
  localparam logic [7:0] MIDI_SYS_RESET = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2
  } alloc_state_t;

endpackage

// File: rtl/midi_voice_table.sv
// Per-voice state store: gate, note, velocity and LRU rank for every voice.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   scan_idx             combinational read port (gate/note/vel/rank)
//   wr_en, wr_idx        single write port; wr_gate=1 starts a note (stores
//   wr_gate, wr_note,    note/vel and makes the voice newest), wr_gate=0
//   wr_vel               only releases the gate
//   gates                registered gate bit of every voice
module midi_voice_table
  import midi_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int VEL_W  = VEL_W_DEF,
  parameter int IDX_W  = $clog2(VOICES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  scan_idx,
  output logic              scan_gate,
  output logic [NOTE_W-1:0] scan_note,
  output logic [VEL_W-1:0]  scan_vel,
  output logic [IDX_W-1:0]  scan_rank,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_gate,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic [VEL_W-1:0]  wr_vel,
  output logic [VOICES-1:0] gates
);

  logic [VOICES-1:0] gate;
  logic [NOTE_W-1:0] note [VOICES];
  logic [VEL_W-1:0]  vel  [VOICES];
  logic [IDX_W-1:0]  rank [VOICES];
  logic [IDX_W-1:0]  wr_rank;

  assign scan_gate = gate[scan_idx];
  assign scan_note = note[scan_idx];
  assign scan_vel  = vel[scan_idx];
  assign scan_rank = rank[scan_idx];
  assign wr_rank   = rank[wr_idx];
  assign gates     = gate;

  // Voice state update; ranks stay a permutation of 0..VOICES-1 (0 = newest)
  always_ff @(posedge clk) begin
    if (rst) begin
      gate <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note[i] <= '0;
        vel[i]  <= '0;
        rank[i] <= IDX_W'(VOICES - 1 - i);
      end
    end else if (wr_en) begin
      for (int i = 0; i < VOICES; i++) begin
        if (IDX_W'(i) == wr_idx) begin
          gate[i] <= wr_gate;
          if (wr_gate) begin
            note[i] <= wr_note;
            vel[i]  <= wr_vel;
            rank[i] <= '0;
          end
        end else if (wr_gate && (rank[i] < wr_rank)) begin
          rank[i] <= rank[i] + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// Voice allocator between the MIDI parser and the synth voice bank.
// Each accepted event scans all voices (one per CE cycle, fixed latency) and
// then issues at most one write: retrigger the voice holding the same note,
// else the lowest free voice, else steal the least-recently-allocated voice.
// Ports:
//   CLK, RST, CE                clock, sync active-high reset, clock enable
//   EV_VALID/ON/NOTE/VEL        event from parser (note-on with vel 0 = off)
//   BUSY, DROPPED               allocator busy; pulse when an event is lost
//   VOICE_WE/IDX/GATE/NOTE/VEL  registered write to the voice bank
//   GATES                       current gate bit of every voice
module midi_voice_alloc
  import midi_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int VEL_W  = VEL_W_DEF,
  localparam int IDX_W = $clog2(VOICES)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic              EV_VALID,
  input  logic              EV_ON,
  input  logic [NOTE_W-1:0] EV_NOTE,
  input  logic [VEL_W-1:0]  EV_VEL,
  output logic              BUSY,
  output logic              DROPPED,
  output logic              VOICE_WE,
  output logic [IDX_W-1:0]  VOICE_IDX,
  output logic              VOICE_GATE,
  output logic [NOTE_W-1:0] VOICE_NOTE,
  output logic [VEL_W-1:0]  VOICE_VEL,
  output logic [VOICES-1:0] GATES
);

  alloc_state_t      state;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;
  logic [VEL_W-1:0]  ev_vel;
  logic [IDX_W-1:0]  scan_idx;
  logic              match_found, free_found;
  logic [IDX_W-1:0]  match_idx, free_idx, oldest_idx;

  logic              scan_gate;
  logic [NOTE_W-1:0] scan_note;
  logic [VEL_W-1:0]  scan_vel;
  logic [IDX_W-1:0]  scan_rank;

  // Scan results including the voice being looked at this cycle, so the
  // final decision is ready on the last SCAN cycle.
  logic              match_found_n, free_found_n;
  logic [IDX_W-1:0]  match_idx_n, free_idx_n, oldest_idx_n, target;
  logic              last_scan, do_write, table_we;
  logic              unused_scan_vel;

  assign BUSY            = (state != IDLE);
  assign unused_scan_vel = ^scan_vel;  // velocity readback is not needed here

  // Fold the current voice into the running scan result and pick the target
  always_comb begin
    match_found_n = match_found;
    match_idx_n   = match_idx;
    free_found_n  = free_found;
    free_idx_n    = free_idx;
    oldest_idx_n  = oldest_idx;
    if (!match_found && scan_gate && (scan_note == ev_note)) begin
      match_found_n = 1'b1;
      match_idx_n   = scan_idx;
    end else begin
      match_found_n = match_found;
    end
    if (!free_found && !scan_gate) begin
      free_found_n = 1'b1;
      free_idx_n   = scan_idx;
    end else begin
      free_found_n = free_found;
    end
    if (scan_rank == IDX_W'(VOICES - 1)) begin
      oldest_idx_n = scan_idx;
    end else begin
      oldest_idx_n = oldest_idx;
    end
    if (match_found_n) begin
      target = match_idx_n;
    end else if (free_found_n) begin
      target = free_idx_n;
    end else begin
      target = oldest_idx_n;
    end
    last_scan = (scan_idx == IDX_W'(VOICES - 1));
    // A note-off for a note that is not sounding writes nothing
    do_write  = ev_on || match_found_n;
    table_we  = CE && (state == SCAN) && last_scan && do_write;
  end

  midi_voice_table #(
    .VOICES (VOICES),
    .NOTE_W (NOTE_W),
    .VEL_W  (VEL_W),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk       (CLK),
    .rst       (RST),
    .scan_idx  (scan_idx),
    .scan_gate (scan_gate),
    .scan_note (scan_note),
    .scan_vel  (scan_vel),
    .scan_rank (scan_rank),
    .wr_en     (table_we),
    .wr_idx    (target),
    .wr_gate   (ev_on),
    .wr_note   (ev_note),
    .wr_vel    (ev_vel),
    .gates     (GATES)
  );

  // Allocator FSM, event latch, scan registers and registered voice outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      ev_on       <= 1'b0;
      ev_note     <= '0;
      ev_vel      <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      oldest_idx  <= '0;
      DROPPED     <= 1'b0;
      VOICE_WE    <= 1'b0;
      VOICE_IDX   <= '0;
      VOICE_GATE  <= 1'b0;
      VOICE_NOTE  <= '0;
      VOICE_VEL   <= '0;
    end else if (CE) begin
      DROPPED  <= EV_VALID && (state != IDLE);
      VOICE_WE <= 1'b0;
      case (state)
        IDLE: begin
          if (EV_VALID) begin
            ev_on       <= EV_ON && (EV_VEL != '0);
            ev_note     <= EV_NOTE;
            ev_vel      <= EV_VEL;
            scan_idx    <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            oldest_idx  <= '0;
            state       <= SCAN;
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          match_found <= match_found_n;
          match_idx   <= match_idx_n;
          free_found  <= free_found_n;
          free_idx    <= free_idx_n;
          oldest_idx  <= oldest_idx_n;
          scan_idx    <= scan_idx + IDX_W'(1);
          if (last_scan) begin
            state <= WRITE;
            if (do_write) begin
              VOICE_WE   <= 1'b1;
              VOICE_IDX  <= target;
              VOICE_GATE <= ev_on;
              VOICE_NOTE <= ev_note;  // equals the stored note on a match
              VOICE_VEL  <= ev_vel;
            end else begin
              VOICE_WE <= 1'b0;
            end
          end else begin
            state <= SCAN;
          end
        end
        WRITE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end else begin
      state <= state;
    end
  end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Self-checking bench for midi_voice_alloc (VOICES=4): a table of events with
// hand-computed expected writes, plus sequences for drop, reset abort and CE.
module tb_midi_voice_alloc;

  logic       CLK = 1'b0;
  logic       RST, CE, EV_VALID, EV_ON;
  logic [6:0] EV_NOTE, EV_VEL;
  logic       BUSY, DROPPED, VOICE_WE, VOICE_GATE;
  logic [1:0] VOICE_IDX;
  logic [6:0] VOICE_NOTE, VOICE_VEL;
  logic [3:0] GATES;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    logic       we;
    logic [1:0] idx;
    logic       gate;
    logic [6:0] onote;
    logic [6:0] ovel;
    logic [3:0] gates;
  } vec_t;

  vec_t vecs[13];

  midi_voice_alloc dut (
    .CLK(CLK), .RST(RST), .CE(CE), .EV_VALID(EV_VALID), .EV_ON(EV_ON),
    .EV_NOTE(EV_NOTE), .EV_VEL(EV_VEL), .BUSY(BUSY), .DROPPED(DROPPED),
    .VOICE_WE(VOICE_WE), .VOICE_IDX(VOICE_IDX), .VOICE_GATE(VOICE_GATE),
    .VOICE_NOTE(VOICE_NOTE), .VOICE_VEL(VOICE_VEL), .GATES(GATES)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one event for one cycle; returns in the first SCAN cycle
  task automatic offer(input logic on, input logic [6:0] note, input logic [6:0] vel);
    EV_VALID = 1'b1;
    EV_ON    = on;
    EV_NOTE  = note;
    EV_VEL   = vel;
    tick();
    EV_VALID = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    offer(v.on, v.note, v.vel);
    for (int k = 1; k <= 4; k++) begin
      check({tag, "_we_early"}, VOICE_WE, 1'b0);
      check({tag, "_busy"}, BUSY, 1'b1);
      tick();
    end
    check({tag, "_we"}, VOICE_WE, v.we);
    if (v.we) begin
      check({tag, "_idx"}, VOICE_IDX, v.idx);
      check({tag, "_gate"}, VOICE_GATE, v.gate);
      check({tag, "_note"}, VOICE_NOTE, v.onote);
      check({tag, "_vel"}, VOICE_VEL, v.ovel);
    end
    check({tag, "_gates"}, GATES, v.gates);
    check({tag, "_busy_wr"}, BUSY, 1'b1);
    tick();
    check({tag, "_we_end"}, VOICE_WE, 1'b0);
    check({tag, "_idle"}, BUSY, 1'b0);
  endtask

  initial begin
    int  cnt;
    bit  seen;
    bit  stray;

    //           on    note    vel    we    idx   gate  onote   ovel   gates
    vecs[0]  = '{1'b1, 7'd60, 7'd100, 1'b1, 2'd0, 1'b1, 7'd60, 7'd100, 4'b0001};
    vecs[1]  = '{1'b1, 7'd62, 7'd80,  1'b1, 2'd1, 1'b1, 7'd62, 7'd80,  4'b0011};
    vecs[2]  = '{1'b1, 7'd64, 7'd70,  1'b1, 2'd2, 1'b1, 7'd64, 7'd70,  4'b0111};
    vecs[3]  = '{1'b1, 7'd65, 7'd60,  1'b1, 2'd3, 1'b1, 7'd65, 7'd60,  4'b1111};
    vecs[4]  = '{1'b1, 7'd67, 7'd50,  1'b1, 2'd0, 1'b1, 7'd67, 7'd50,  4'b1111};
    vecs[5]  = '{1'b1, 7'd62, 7'd90,  1'b1, 2'd1, 1'b1, 7'd62, 7'd90,  4'b1111};
    vecs[6]  = '{1'b0, 7'd62, 7'd40,  1'b1, 2'd1, 1'b0, 7'd62, 7'd40,  4'b1101};
    vecs[7]  = '{1'b0, 7'd70, 7'd0,   1'b0, 2'd0, 1'b0, 7'd0,  7'd0,   4'b1101};
    vecs[8]  = '{1'b1, 7'd64, 7'd0,   1'b1, 2'd2, 1'b0, 7'd64, 7'd0,   4'b1001};
    vecs[9]  = '{1'b1, 7'd72, 7'd33,  1'b1, 2'd1, 1'b1, 7'd72, 7'd33,  4'b1011};
    vecs[10] = '{1'b1, 7'd74, 7'd20,  1'b1, 2'd2, 1'b1, 7'd74, 7'd20,  4'b1111};
    vecs[11] = '{1'b1, 7'd76, 7'd10,  1'b1, 2'd3, 1'b1, 7'd76, 7'd10,  4'b1111};
    vecs[12] = '{1'b1, 7'd77, 7'd11,  1'b1, 2'd0, 1'b1, 7'd77, 7'd11,  4'b1111};

    RST = 1'b1; CE = 1'b1; EV_VALID = 1'b0; EV_ON = 1'b0; EV_NOTE = 7'd0; EV_VEL = 7'd0;
    tick(); tick();
    RST = 1'b0;

    // Reset state
    check("rst_busy", BUSY, 1'b0);
    check("rst_dropped", DROPPED, 1'b0);
    check("rst_we", VOICE_WE, 1'b0);
    check("rst_idx", VOICE_IDX, 2'd0);
    check("rst_note", VOICE_NOTE, 7'd0);
    check("rst_vel", VOICE_VEL, 7'd0);
    check("rst_gate", VOICE_GATE, 1'b0);
    check("rst_gates", GATES, 4'b0000);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Event during BUSY is dropped; ranks now make voice 1 the oldest
    offer(1'b1, 7'd80, 7'd5);
    EV_VALID = 1'b1; EV_ON = 1'b1; EV_NOTE = 7'd81; EV_VEL = 7'd7;
    tick();
    EV_VALID = 1'b0;
    check("drop_pulse", DROPPED, 1'b1);
    check("drop_busy", BUSY, 1'b1);
    tick();
    check("drop_clear", DROPPED, 1'b0);
    tick(); tick();
    check("drop_we", VOICE_WE, 1'b1);
    check("drop_idx", VOICE_IDX, 2'd1);
    check("drop_note", VOICE_NOTE, 7'd80);
    check("drop_vel", VOICE_VEL, 7'd5);
    tick();
    check("drop_idle", BUSY, 1'b0);
    stray = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (VOICE_WE) stray = 1'b1;
      tick();
    end
    check("drop_no_second_we", stray, 1'b0);

    // Reset in the second SCAN cycle aborts the event
    offer(1'b1, 7'd90, 7'd9);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (VOICE_WE) stray = 1'b1;
      tick();
    end
    check("abort_no_we", stray, 1'b0);
    check("abort_gates", GATES, 4'b0000);
    check("abort_busy", BUSY, 1'b0);
    check("abort_note", VOICE_NOTE, 7'd0);
    run_vec('{1'b1, 7'd50, 7'd50, 1'b1, 2'd0, 1'b1, 7'd50, 7'd50, 4'b0001}, 13);

    // CE toggling stretches latency to VOICES+1 CE-high cycles
    offer(1'b1, 7'd51, 7'd1);
    cnt  = 1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      CE = k[0];
      tick();
      if (CE) cnt++;
      if (VOICE_WE) seen = 1'b1;
    end
    check("ce_we_seen", seen, 1'b1);
    check("ce_latency", cnt, 5);
    check("ce_idx", VOICE_IDX, 2'd1);
    check("ce_note", VOICE_NOTE, 7'd51);
    CE = 1'b0;
    tick();
    check("ce_we_hold", VOICE_WE, 1'b1);
    check("ce_busy_hold", BUSY, 1'b1);
    CE = 1'b1;
    tick();
    check("ce_we_end", VOICE_WE, 1'b0);
    check("ce_idle", BUSY, 1'b0);
    check("ce_gates", GATES, 4'b0011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
